alu_op_scheduler: RTL
=====================

Name: alu_op_scheduler

Overview:
- Shares the single 16-bit ALU datapath between NUM_REQ independent requesters.
- Round-robin arbitration selects one request at a time.
- The selected operands and function are driven onto the ALU for one enable cycle.
- The block waits for the matching class flag, captures and muxes the class result into one 32-bit response tagged with the requester ID, and holds it until the consumer accepts it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width (= clog2(NUM_REQ)).
- TIMEOUT, 8, maximum WAIT cycles for the ALU class flag before an error response.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; the request is taken on valid&ready.
- req_a  in  NUM_REQ*16  packed operand A per requester.
- req_b  in  NUM_REQ*16  packed operand B per requester.
- req_func  in  NUM_REQ*4  packed ALU_FUNC per requester.
- alu_A / alu_B  out  16  operands to the ALU.
- alu_FUNC  out  4  function to the ALU.
- alu_EN  out  1  ALU enable; pulses for one cycle per operation.
- alu_Arith_OUT  in  32, alu_Logic_OUT  in  16, alu_Shift_OUT  in  16, alu_CMP_OUT  in  3, alu_Carry_OUT  in  1  ALU results.
- alu_Arith_Flag / alu_Logic_Flag / alu_Shift_Flag / alu_CMP_Flag  in  1 each  ALU result-valid flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  ID of the requester that owns the response.
- rsp_data  out  32  result.
- rsp_carry  out  1  carry (arith class only).
- rsp_err  out  1  timeout indicator.

Behaviour:
- Reset: synchronous active-high RST. State=IDLE; RR pointer=0. All outputs are 0 after reset: req_ready, alu_*, rsp_*. RST in any state, including mid-WAIT or RESP, abandons the in-flight operation with no response.
- Class decode from FUNC[3:2]: 00=ARITH, 01=LOGIC, 10=CMP, 11=SHIFT.
- IDLE:
  - If any req_valid, grant the first valid index at or after the pointer, wrapping.
  - req_ready[g]=1 for that same cycle (combinational from state + req_valid).
  - Latch A, B, FUNC and ID. Pointer <= g+1 mod NUM_REQ. Next state is ISSUE.
  - With no request, remain in IDLE with pointer unchanged.
- ISSUE: alu_A/B/FUNC driven from the latches (held stable through WAIT); alu_EN=1 for exactly this cycle; wait counter cleared. Next state is WAIT.
- WAIT:
  - alu_EN=0. Sample the class flag selected by the latched FUNC; flags of other classes are ignored.
  - Flag=1: capture the result and next state is RESP.
    - ARITH: rsp_data=Arith_OUT, rsp_carry=Carry_OUT.
    - LOGIC / SHIFT: zero-extend 16->32.
    - CMP: zero-extend 3->32.
    - rsp_carry=0 for non-ARITH; rsp_err=0.
  - Counter reaches TIMEOUT without the flag: rsp_data=0, rsp_carry=0, rsp_err=1, and next state is RESP.
- RESP:
  - rsp_valid=1; rsp_id/data/carry/err held stable until rsp_ready.
  - On rsp_valid&rsp_ready, rsp_valid is cleared next cycle and next state is IDLE. No requests are granted while in RESP.
- Latency: with the ALU flag one cycle after alu_EN, rsp_valid rises 3 cycles after the grant cycle. The minimum per-op period is 4 cycles with rsp_ready held high.
- Simultaneous events: req_valid deasserted after its grant does not cancel the operation. A requester re-requesting while its previous response is pending is granted in the next IDLE per RR order.

Decomposition:
- Shared package alu_sched_pkg:
  - enum state_t {IDLE, ISSUE, WAIT, RESP}.
  - enum alu_class_t {CLS_ARITH, CLS_LOGIC, CLS_CMP, CLS_SHIFT}.
  - Function func_class(func[3:0]).
  - Localparams for the 4-bit ALU_FUNC encodings.
- One sub-module rr_arbiter: parameter N; inputs req and pointer; outputs one-hot grant and encoded index. Purely combinational, instantiated once.

Test Plan:
- Only req 0 valid; A=0xFFFF, B=0x0001, FUNC=0000 (add) -> req_ready[0] pulses; alu_EN one cycle later; rsp_valid 3 cycles after grant; rsp_id=0, rsp_data=0x00010000, rsp_carry = model Carry_OUT, rsp_err=0.
- Req 2: A=0xF0F0, B=0x0FF0, FUNC=0100 (AND) -> rsp_id=2, rsp_data=0x000000F0, rsp_carry=0.
- All 4 requesters valid continuously from reset, rsp_ready=1 -> grants in order 0,1,2,3,0, spaced 4 cycles apart; rsp_id sequence 0,1,2,3,0.
- ALU model suppresses all flags, TIMEOUT=8 -> rsp_valid 8 WAIT cycles after ISSUE with rsp_err=1 and rsp_data=0. The next request is still served normally.
- rsp_ready held low 5 cycles while req 1 is pending -> rsp fields stable for all 5 cycles; req_ready stays 0; req 1 is granted the cycle after the accept cycle.
- RST asserted during WAIT -> the next cycle shows all outputs 0, state IDLE, pointer 0; no response for the aborted op. A request issued after reset from req 3 with req 0 also valid -> req 0 is granted first.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and ALU function encodings for the ALU operation scheduler.
// The class of an operation is carried in the top two bits of its function code.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_ARITH = 2'b00,
        CLS_LOGIC = 2'b01,
        CLS_CMP   = 2'b10,
        CLS_SHIFT = 2'b11
    } alu_class_t;

    localparam logic [3:0] FUNC_ADD  = 4'b0000;
    localparam logic [3:0] FUNC_SUB  = 4'b0001;
    localparam logic [3:0] FUNC_MUL  = 4'b0010;
    localparam logic [3:0] FUNC_DIV  = 4'b0011;
    localparam logic [3:0] FUNC_AND  = 4'b0100;
    localparam logic [3:0] FUNC_OR   = 4'b0101;
    localparam logic [3:0] FUNC_XOR  = 4'b0110;
    localparam logic [3:0] FUNC_NOR  = 4'b0111;
    localparam logic [3:0] FUNC_CMP  = 4'b1000;
    localparam logic [3:0] FUNC_SHL  = 4'b1100;
    localparam logic [3:0] FUNC_SHR  = 4'b1101;

    localparam int OPND_W = 16;
    localparam int RSP_W  = 32;

    function automatic alu_class_t func_class(input logic [3:0] func);
        return alu_class_t'(func[3:2]);
    endfunction

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around, and reports its index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Time-shares one ALU between NUM_REQ requesters: round-robin grant, one-cycle
// issue, wait for the class flag (or time out), then hold a tagged response.
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*16-1:0]   req_a,
    input  logic [NUM_REQ*16-1:0]   req_b,
    input  logic [NUM_REQ*4-1:0]    req_func,
    output logic [15:0]             alu_A,
    output logic [15:0]             alu_B,
    output logic [3:0]              alu_FUNC,
    output logic                    alu_EN,
    input  logic [31:0]             alu_Arith_OUT,
    input  logic [15:0]             alu_Logic_OUT,
    input  logic [15:0]             alu_Shift_OUT,
    input  logic [2:0]              alu_CMP_OUT,
    input  logic                    alu_Carry_OUT,
    input  logic                    alu_Arith_Flag,
    input  logic                    alu_Logic_Flag,
    input  logic                    alu_Shift_Flag,
    input  logic                    alu_CMP_Flag,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_data,
    output logic                    rsp_carry,
    output logic                    rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [15:0] a_arr    [NUM_REQ];
    logic [15:0] b_arr    [NUM_REQ];
    logic [3:0]  func_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi]    = req_a[gi*16 +: 16];
        assign b_arr[gi]    = req_b[gi*16 +: 16];
        assign func_arr[gi] = req_func[gi*4 +: 4];
    end

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [15:0]       a_q, a_d, b_q, b_d;
    logic [3:0]        func_q, func_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              alu_en_q, alu_en_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               class_flag;
    logic [31:0]        class_data;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Gated by RST so a request is never acknowledged on a cycle that cannot latch it.
    assign req_ready = (state_q == IDLE && !RST) ? grant : '0;

    always_comb begin
        class_flag = 1'b0;
        class_data = '0;
        case (func_class(func_q))
            CLS_ARITH: begin
                class_flag = alu_Arith_Flag;
                class_data = alu_Arith_OUT;
            end
            CLS_LOGIC: begin
                class_flag = alu_Logic_Flag;
                class_data = {16'h0000, alu_Logic_OUT};
            end
            CLS_CMP: begin
                class_flag = alu_CMP_Flag;
                class_data = {29'h0, alu_CMP_OUT};
            end
            default: begin
                class_flag = alu_Shift_Flag;
                class_data = {16'h0000, alu_Shift_OUT};
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        func_d      = func_q;
        id_d        = id_q;
        alu_en_d    = 1'b0;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    a_d      = a_arr[grant_idx];
                    b_d      = b_arr[grant_idx];
                    func_d   = func_arr[grant_idx];
                    id_d     = grant_idx;
                    ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    alu_en_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (class_flag) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = class_data;
                    rsp_carry_d = (func_class(func_q) == CLS_ARITH) ? alu_Carry_OUT : 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_carry_d = 1'b0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            func_q      <= '0;
            id_q        <= '0;
            alu_en_q    <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            func_q      <= func_d;
            id_q        <= id_d;
            alu_en_q    <= alu_en_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_A     = a_q;
    assign alu_B     = b_q;
    assign alu_FUNC  = func_q;
    assign alu_EN    = alu_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_err   = rsp_err_q;

endmodule
